// File: rtl/seg7_capture.sv
// seg7_capture: reads digit codes back from a multiplexed, active-low
// 7-segment bus (one-hot active-low anodes + shared segment lines).
// A 2-flop synchronizer feeds a settle/sample FSM. One sample is taken per
// anode visit. A per-digit stability filter commits a code only after
// STABLE_CNT identical decodes.
// Optional feature macro: SEG7_CAP_DP_EN. When it is defined, the decimal
// point is masked from decode and reported on oDP.

// Per-digit stability filter and commit registers.
module seg7_cap_digit #(
  parameter int STABLE_CNT = 3
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       smp,
  input  logic [3:0] code,
  input  logic       ill,
`ifdef SEG7_CAP_DP_EN
  input  logic       dp,
  output logic       dpo,
`endif
  output logic [3:0] dig,
  output logic       valid,
  output logic       err,
  output logic       chg
);
  localparam logic [2:0] SC = 3'(STABLE_CNT);

  logic [3:0] cand;
  logic       cill;
  logic [2:0] mcnt;
  logic [2:0] ncnt;
  logic       commit;

  // Next match count, commit decision, and whether the commit is visible.
  always_comb begin
    ncnt = 3'd1;
    if ((code == cand) && (ill == cill))
      ncnt = (mcnt == SC) ? SC : mcnt + 3'd1;
    commit = smp && (ncnt == SC);
    chg = 1'b0;
    if (commit) begin
      if (ill) chg = valid || !err;
      else     chg = (dig != code) || !valid || err
`ifdef SEG7_CAP_DP_EN
                     || (dpo != dp)
`endif
                     ;
    end
  end

  // Candidate tracking and commit registers. Illegal commits keep dig.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cand  <= '0;
      cill  <= 1'b0;
      mcnt  <= '0;
      dig   <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
`ifdef SEG7_CAP_DP_EN
      dpo   <= 1'b0;
`endif
    end else begin
      if (smp) begin
        cand <= code;
        cill <= ill;
        mcnt <= ncnt;
      end
      if (commit) begin
        if (ill) begin
          valid <= 1'b0;
          err   <= 1'b1;
        end else begin
          dig   <= code;
          valid <= 1'b1;
          err   <= 1'b0;
`ifdef SEG7_CAP_DP_EN
          dpo   <= dp;
`endif
        end
      end
    end
  end
endmodule

module seg7_capture #(
  parameter int NUM_DIGITS   = 4,
  parameter int SAMPLE_DELAY = 2,
  parameter int STABLE_CNT   = 3
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [NUM_DIGITS-1:0]   iAN,
  input  logic [7:0]              iSEG,
  output logic [4*NUM_DIGITS-1:0] oDIG,
  output logic [NUM_DIGITS-1:0]   oVALID,
  output logic [NUM_DIGITS-1:0]   oERR,
`ifdef SEG7_CAP_DP_EN
  output logic [NUM_DIGITS-1:0]   oDP,
`endif
  output logic                    oUPD,
  output logic [((NUM_DIGITS>1)?$clog2(NUM_DIGITS):1)-1:0] oUPD_IDX
);
  localparam int ND = NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0] SD = 4'(SAMPLE_DELAY);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} st_t;

  logic [ND-1:0] an_s1, an_s2, an_q, an_low;
  logic [7:0]    seg_s1, seg_s2, pat;
  st_t           st;
  logic [3:0]    cnt;
  logic          oh;
  logic [IW-1:0] sidx;
  logic [3:0]    dcode;
  logic          dill;
  logic [ND-1:0] chg;

  // Two-flop synchronizer on anode and segment buses; idle value is all-high.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      an_s1  <= '1;
      an_s2  <= '1;
      seg_s1 <= '1;
      seg_s2 <= '1;
    end else begin
      an_s1  <= iAN;
      an_s2  <= an_s1;
      seg_s1 <= iSEG;
      seg_s2 <= seg_s1;
    end
  end

  // Exactly one anode low.
  assign an_low = ~an_s2;
  assign oh     = (an_low != '0) && ((an_low & (an_low - ND'(1))) == '0);

  // Settle/sample FSM: one sample per anode visit after SAMPLE_DELAY cycles.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      st   <= IDLE;
      an_q <= '1;
      cnt  <= '0;
    end else begin
      case (st)
        IDLE: if (oh) begin
          st   <= SETTLE;
          an_q <= an_s2;
          cnt  <= 4'd1;
        end
        SETTLE: begin
          if (!oh)                st <= IDLE;
          else if (an_s2 != an_q) begin
            an_q <= an_s2;
            cnt  <= 4'd1;
          end
          else if (cnt == SD)     st <= SAMPLE;
          else                    cnt <= cnt + 4'd1;
        end
        SAMPLE: st <= HOLD;
        HOLD: begin
          if (!oh) st <= IDLE;
          else if (an_s2 != an_q) begin
            st   <= SETTLE;
            an_q <= an_s2;
            cnt  <= 4'd1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Active digit index from the latched one-hot anode.
  always_comb begin
    sidx = '0;
    for (int i = 0; i < ND; i++)
      if (!an_q[i]) sidx = IW'(i);
  end

`ifdef SEG7_CAP_DP_EN
  assign pat = {1'b1, seg_s2[6:0]};
`else
  assign pat = seg_s2;
`endif

  // Segment pattern to digit code; anything outside the table is illegal.
  always_comb begin
    dill  = 1'b0;
    dcode = 4'd0;
    case (pat)
      8'hC0: dcode = 4'd0;
      8'hF9: dcode = 4'd1;
      8'hA4: dcode = 4'd2;
      8'hB0: dcode = 4'd3;
      8'h99: dcode = 4'd4;
      8'h92: dcode = 4'd5;
      8'h82: dcode = 4'd6;
      8'hF8: dcode = 4'd7;
      8'h80: dcode = 4'd8;
      8'h90: dcode = 4'd9;
      8'hC6: dcode = 4'd10;
      8'hFF: dcode = 4'd15;
      default: dill = 1'b1;
    endcase
  end

  for (genvar g = 0; g < ND; g++) begin : g_dig
    seg7_cap_digit #(.STABLE_CNT(STABLE_CNT)) u_dig (
      .iCLK  (iCLK),
      .iRST_N(iRST_N),
      .smp   ((st == SAMPLE) && !an_q[g]),
      .code  (dcode),
      .ill   (dill),
`ifdef SEG7_CAP_DP_EN
      .dp    (~seg_s2[7]),
      .dpo   (oDP[g]),
`endif
      .dig   (oDIG[4*g +: 4]),
      .valid (oVALID[g]),
      .err   (oERR[g]),
      .chg   (chg[g])
    );
  end

  // Update pulse on any visible commit change; index held until the next one.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oUPD     <= 1'b0;
      oUPD_IDX <= '0;
    end else begin
      oUPD <= |chg;
      if (|chg) oUPD_IDX <= sidx;
    end
  end
endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture (default parameters).
module tb_seg7_capture;
  localparam int ND = 4;

  logic          iCLK = 1'b0;
  logic          iRST_N;
  logic [ND-1:0] iAN;
  logic [7:0]    iSEG;
  logic [4*ND-1:0] oDIG;
  logic [ND-1:0] oVALID, oERR;
  logic          oUPD;
  logic [1:0]    oUPD_IDX;
`ifdef SEG7_CAP_DP_EN
  logic [ND-1:0] oDP;
`endif

  int errs = 0;
  int checks = 0;
  int upd_n = 0;
  int base;
  logic [1:0] last_idx = '0;

  always #5 iCLK = ~iCLK;

  seg7_capture dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .iAN     (iAN),
    .iSEG    (iSEG),
    .oDIG    (oDIG),
    .oVALID  (oVALID),
    .oERR    (oERR),
`ifdef SEG7_CAP_DP_EN
    .oDP     (oDP),
`endif
    .oUPD    (oUPD),
    .oUPD_IDX(oUPD_IDX)
  );

  // Count every update pulse, including any spurious one during reset.
  always @(negedge iCLK) if (oUPD) begin
    upd_n++;
    last_idx = oUPD_IDX;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n cycles; returns just after a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge iCLK);
    #1;
  endtask

  // One full anode visit followed by an idle gap.
  task automatic visit(input logic [ND-1:0] an, input logic [7:0] seg);
    iAN = an; iSEG = seg;
    cyc(6);
    iAN = '1;
    cyc(4);
  endtask

  initial begin
    iRST_N = 1'b0;
    iAN = '1; iSEG = '1;
    for (int k = 0; k < 5; k++) begin
      iAN = 4'($urandom); iSEG = 8'($urandom);
      cyc(1);
    end
    chk("rst_dig", 32'(oDIG), 32'h0);
    chk("rst_valid", 32'(oVALID), 32'h0);
    chk("rst_err", 32'(oERR), 32'h0);
    chk("rst_upd", 32'(oUPD), 32'h0);
    iAN = '1; iSEG = '1;
    iRST_N = 1'b1;
    cyc(5);
    chk("post_rst_dig", 32'(oDIG), 32'h0);
    chk("post_rst_valid", 32'(oVALID), 32'h0);
    chk("post_rst_updn", 32'(upd_n), 32'd0);

    // Digit 0: "2" needs three visits; third one checked edge-exact.
    visit(4'b1110, 8'hA4);
    visit(4'b1110, 8'hA4);
    chk("d0_two_visits_valid", 32'(oVALID), 32'h0);
    chk("d0_two_visits_updn", 32'(upd_n), 32'd0);
    iAN = 4'b1110; iSEG = 8'hA4;
    cyc(5);
    chk("d0_before_commit", 32'(oVALID), 32'h0);
    cyc(1);
    chk("d0_commit_valid", 32'(oVALID), 32'b0001);
    chk("d0_commit_dig", 32'(oDIG[3:0]), 32'd2);
    chk("d0_commit_upd", 32'(oUPD), 32'd1);
    chk("d0_commit_idx", 32'(oUPD_IDX), 32'd0);
    iAN = '1;
    cyc(4);
    chk("d0_single_upd", 32'(upd_n), 32'd1);
    visit(4'b1110, 8'hA4);
    chk("d0_recommit_silent", 32'(upd_n), 32'd1);

    // Digit 1: illegal pattern, then "C".
    repeat (3) visit(4'b1101, 8'h00);
    chk("d1_err", 32'(oERR), 32'b0010);
    chk("d1_err_valid", 32'(oVALID), 32'b0001);
    chk("d1_err_dig", 32'(oDIG[7:4]), 32'd0);
    chk("d1_err_updn", 32'(upd_n), 32'd2);
    chk("d1_err_idx", 32'(last_idx), 32'd1);
    repeat (3) visit(4'b1101, 8'hC6);
    chk("d1_c_dig", 32'(oDIG[7:4]), 32'd10);
    chk("d1_c_err", 32'(oERR), 32'b0000);
    chk("d1_c_valid", 32'(oVALID), 32'b0011);
    chk("d1_c_updn", 32'(upd_n), 32'd3);

    // Digit 2: alternating decodes never stabilise.
    for (int v = 0; v < 10; v++) visit(4'b1011, (v % 2 == 0) ? 8'h99 : 8'h92);
    chk("d2_alt_valid", 32'(oVALID), 32'b0011);
    chk("d2_alt_dig", 32'(oDIG[11:8]), 32'd0);
    chk("d2_alt_updn", 32'(upd_n), 32'd3);

    // Digit 0 primed with two "3" samples; non-one-hot and short visits must not sample.
    visit(4'b1110, 8'hB0);
    visit(4'b1110, 8'hB0);
    chk("d0_prime_updn", 32'(upd_n), 32'd3);
    iAN = 4'b1100; iSEG = 8'hF9;
    cyc(20);
    iAN = '1;
    cyc(4);
    iAN = 4'b1110; iSEG = 8'hB0;
    cyc(2);
    iAN = '1;
    cyc(4);
    chk("short_visit_updn", 32'(upd_n), 32'd3);
    chk("short_visit_dig", 32'(oDIG[3:0]), 32'd2);
    visit(4'b1110, 8'hB0);
    chk("d0_three_dig", 32'(oDIG[3:0]), 32'd3);
    chk("d0_three_updn", 32'(upd_n), 32'd4);
    chk("d0_three_idx", 32'(last_idx), 32'd0);

    // Pattern 0x40: decimal point lit on "0".
    repeat (3) visit(4'b1011, 8'h40);
`ifdef SEG7_CAP_DP_EN
    chk("d2_dp_valid", 32'(oVALID), 32'b0111);
    chk("d2_dp_dp", 32'(oDP), 32'b0100);
`else
    chk("d2_40_err", 32'(oERR), 32'b0100);
    chk("d2_40_valid", 32'(oVALID), 32'b0011);
`endif
    chk("d2_40_updn", 32'(upd_n), 32'd5);
    chk("d2_40_idx", 32'(last_idx), 32'd2);

    // Reset while digit 3 is settling.
    iAN = 4'b0111; iSEG = 8'hFF;
    cyc(3);
    iRST_N = 1'b0;
    #1;
    chk("midrst_dig", 32'(oDIG), 32'h0);
    chk("midrst_valid", 32'(oVALID), 32'h0);
    chk("midrst_err", 32'(oERR), 32'h0);
    cyc(1);
    iAN = '1;
    iRST_N = 1'b1;
    cyc(4);
    base = upd_n;
    repeat (3) visit(4'b0111, 8'hFF);
    chk("d3_blank_dig", 32'(oDIG[15:12]), 32'd15);
    chk("d3_blank_valid", 32'(oVALID), 32'b1000);
    chk("d3_blank_updn", 32'(upd_n - base), 32'd1);
    chk("d3_blank_idx", 32'(last_idx), 32'd3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Recovers digit codes from a multiplexed, active-low 7-segment display bus: anode strobes plus shared segment lines.
- It is the reading end of the segment encoding the display path drives.
- Sits on the test/monitor side: it lets the traffic-light controller's displayed countdown be read back as numeric values per digit, with a stability filter and error flagging.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (anode lines).
- SAMPLE_DELAY, 2, cycles a one-hot anode must hold before the segment bus is sampled (settling time); range 1..15.
- STABLE_CNT, 3, consecutive identical decodes of one digit required before committing; range 1..7.

Ports:
- iCLK  input  1  system clock.
- iRST_N  input  1  asynchronous active-low reset.
- iAN  input  NUM_DIGITS  anode selects, active-low, one-hot when valid; bit i = digit i.
- iSEG  input  8  segment lines, active-low, bit7 = decimal point.
- oDIG  output  4*NUM_DIGITS  committed code per digit; digit i at bits [4i+3:4i].
- oVALID  output  NUM_DIGITS  digit i holds a committed legal code.
- oERR  output  NUM_DIGITS  digit i last committed an illegal pattern.
- oUPD  output  1  one-cycle pulse on any commit that changes oDIG, oVALID or oERR.
- oUPD_IDX  output  clog2(NUM_DIGITS)  digit index for the current oUPD.

Behaviour:
- Reset (async assert, sync release): oDIG=0, oVALID=0, oERR=0, oUPD=0, oUPD_IDX=0. FSM goes to IDLE; synchronizers, candidates and counters clear.
- iAN and iSEG pass through a 2-flop synchronizer. The FSM uses only synchronized values.
- Decode table, pattern -> code:
  - C0->0, F9->1, A4->2, B0->3, 99->4, 92->5, 82->6, F8->7, 80->8, 90->9.
  - C6->10.
  - FF->15 (blank, legal).
  - Anything else is illegal.
- FSM states:
  - IDLE: synced anode not one-hot (all high, or more than one low); nothing sampled. Exits to SETTLE when anode is one-hot, loading settle counter=1.
  - SETTLE: while anode is unchanged, counter increments. When the counter equals SAMPLE_DELAY, go to SAMPLE. A change to a different one-hot value restarts SETTLE with counter=1. A non-one-hot value goes to IDLE.
  - SAMPLE: one cycle. Decode synced iSEG for the active digit, update that digit's candidate/match counter, go to HOLD.
  - HOLD: stays while anode unchanged (exactly one sample per anode visit). A different one-hot value goes to SETTLE (counter=1). A non-one-hot value goes to IDLE.
- Timing: a one-hot iAN applied at edge E with iSEG stable is sampled at edge E+2+SAMPLE_DELAY. The commit registers are visible after edge E+3+SAMPLE_DELAY.
- Per-digit stability filter (candidate 4-bit code + illegal flag, match counter 3-bit):
  - Decode equals candidate (code and legality): counter increments, saturating at STABLE_CNT.
  - Decode differs: candidate=decode, counter=1.
  - Commit happens on the sample where the counter reaches STABLE_CNT. At saturation, further identical samples re-commit.
- Commit of a legal code: oDIG[i]=code, oVALID[i]=1, oERR[i]=0.
- Commit of an illegal pattern: oVALID[i]=0, oERR[i]=1, oDIG[i] unchanged.
- oUPD/oUPD_IDX pulse only when a commit changes oDIG[i], oVALID[i] or oERR[i]. Repeated identical commits are silent.
- Digits are independent. Visiting other digits does not disturb a digit's candidate or counter.
- A digit never visited keeps its reset values indefinitely.
- Reset asserted mid-SETTLE/SAMPLE: all state clears immediately; no partial commit.

Optional Feature:
- Macro SEG7_CAP_DP_EN.
- Defined:
  - bit7 is masked before decode, so patterns match regardless of decimal point.
  - Adds output oDP [NUM_DIGITS], reset 0. It is updated with oDIG on each legal commit to the inverted bit7 of the sampled pattern.
  - A dp-only change counts as a change for oUPD.
- Undefined:
  - bit7 must be 1 for a legal match; e.g. 40 is illegal.
  - No oDP port.

Test Plan:
- Hold iRST_N=0 with random iAN/iSEG, then release -> all outputs 0, no oUPD, until the first full commit.
- iAN=1110, iSEG=A4 for 3 visits (each visit ≥6 cycles, separated by iAN=1111) -> after 3rd visit oDIG[3:0]=2, oVALID=0001, a single oUPD with oUPD_IDX=0; a 4th identical visit gives no oUPD.
- iAN=1101, iSEG=00 for 3 visits -> oERR=0010, oVALID[1]=0, oDIG[7:4]=0; then C6 for 3 visits -> oDIG[7:4]=10, oERR[1]=0, oVALID[1]=1.
- iAN=1011 with iSEG alternating 99/92 each visit for 10 visits -> no commit, oVALID[2]=0, no oUPD.
- iAN=1100 held 20 cycles with iSEG=F9 -> FSM stays IDLE, no candidate change on digits 0/1; then iAN=1110 for 2 cycles only (less than 2+SAMPLE_DELAY) -> no sample taken.
- Mid-SETTLE on digit 3, pull iRST_N low for 1 cycle -> outputs clear immediately; FF for 3 visits on digit 3 -> oDIG[15:12]=15, oVALID[3]=1.
